// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

   // Controller state: IDLE has no usable configuration, RUN is detecting.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Width needed to hold any length value 0..max_len inclusive.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear dominates increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   // Count up on inc, hold at all-ones, clear wins over a coincident inc.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap/non-overlap modes.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no valid configuration loaded; serial input ignored
//   RUN   | configuration latched; shifting bits and detecting
//
// History holds MAX_LEN-1 past bits; together with the incoming bit that
// gives a full MAX_LEN window for the compare, and the oldest bit is never
// needed again.
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter  int MAX_LEN = 16,
   parameter  int CNT_W   = 16,
   localparam int LEN_W   = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               cfg_load,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed,
   output logic               cfg_err
);

   state_t             r_state;
   logic [LEN_W-1:0]   r_len;
   logic [MAX_LEN-1:0] r_pat;
   logic               r_ovl;
   logic [MAX_LEN-2:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic               r_match;
   logic               r_armed;
   logic               r_cfg_err;

   logic               w_accept;
   logic [MAX_LEN-1:0] w_hist_sh;
   logic [LEN_W-1:0]   w_fill_inc;
   logic [MAX_LEN-1:0] w_mask;
   logic               w_hit;

   // Load acceptance, post-shift window, saturating fill and the masked compare.
   always_comb begin
      w_accept   = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
      w_hist_sh  = {r_hist, in_bit};
      w_fill_inc = (r_fill < r_len) ? (r_fill + LEN_W'(1)) : r_fill;
      w_mask     = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (i < int'(r_len));
      end
      w_hit = (r_state == RUN) && in_valid && !cfg_load &&
              (w_fill_inc >= r_len) &&
              (((w_hist_sh ^ r_pat) & w_mask) == '0);
   end

   // Controller FSM: configuration handling, shifting and registered flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_len     <= '0;
         r_pat     <= '0;
         r_ovl     <= 1'b0;
         r_hist    <= '0;
         r_fill    <= '0;
         r_match   <= 1'b0;
         r_armed   <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_match   <= 1'b0;
         r_cfg_err <= 1'b0;
         if (cfg_load) begin
            // A load always restarts the window; any in-flight bit is dropped.
            r_hist <= '0;
            r_fill <= '0;
            if (w_accept) begin
               r_state <= RUN;
               r_armed <= 1'b1;
               r_len   <= cfg_len;
               r_pat   <= cfg_pattern;
               r_ovl   <= cfg_overlap;
            end else begin
               r_state   <= IDLE;
               r_armed   <= 1'b0;
               r_cfg_err <= 1'b1;
            end
         end else if ((r_state == RUN) && in_valid) begin
            r_hist  <= w_hist_sh[MAX_LEN-2:0];
            r_match <= w_hit;
            // Non-overlap restarts the fill so no bit is reused by the next hit.
            r_fill  <= (w_hit && !r_ovl) ? '0 : w_fill_inc;
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_hit),
      .clr (cnt_clr),
      .cnt (match_cnt)
   );

   assign match   = r_match;
   assign armed   = r_armed;
   assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus random traffic against
// a queue-based reference model of the detection rules.
module tb_seq_detect_prog;

   localparam int MAX_LEN = 16;
   localparam int CNT_W   = 2;
   localparam int LEN_W   = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_bit = 1'b0;
   logic               cfg_load = 1'b0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic               cfg_overlap = 1'b0;
   logic               cnt_clr = 1'b0;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               armed;
   logic               cfg_err;

   always #5 clk = ~clk;

   seq_detect_prog #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .cfg_load    (cfg_load),
      .cfg_len     (cfg_len),
      .cfg_pattern (cfg_pattern),
      .cfg_overlap (cfg_overlap),
      .cnt_clr     (cnt_clr),
      .match       (match),
      .match_cnt   (match_cnt),
      .armed       (armed),
      .cfg_err     (cfg_err)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: bits received since the window was last restarted.
   bit                 m_armed = 1'b0;
   int                 m_len   = 0;
   logic [MAX_LEN-1:0] m_pat   = '0;
   bit                 m_ovl   = 1'b0;
   bit                 q[$];
   int                 m_cnt   = 0;
   bit                 e_match = 1'b0;
   bit                 e_err   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic tick(input logic r, input logic v, input logic b,
                       input logic ld, input logic clr);
      bit hit;
      bit ok;
      int ilen;
      rst = r; in_valid = v; in_bit = b; cfg_load = ld; cnt_clr = clr;
      hit = 1'b0;
      e_match = 1'b0;
      e_err = 1'b0;
      if (r) begin
         m_armed = 1'b0;
         q.delete();
         m_cnt = 0;
      end else begin
         if (ld) begin
            q.delete();
            ilen = int'(cfg_len);
            if (ilen >= 2 && ilen <= MAX_LEN) begin
               m_armed = 1'b1;
               m_len = ilen;
               m_pat = cfg_pattern;
               m_ovl = cfg_overlap;
            end else begin
               m_armed = 1'b0;
               e_err = 1'b1;
            end
         end else if (v && m_armed) begin
            q.push_back(b);
            if (q.size() > m_len) void'(q.pop_front());
            if (q.size() == m_len) begin
               ok = 1'b1;
               for (int i = 0; i < m_len; i++)
                  if (q[i] != m_pat[m_len-1-i]) ok = 1'b0;
               if (ok) begin
                  hit = 1'b1;
                  e_match = 1'b1;
                  if (!m_ovl) q.delete();
               end
            end
         end
         if (clr) m_cnt = 0;
         else if (hit && m_cnt < CNT_MAX) m_cnt++;
      end
      @(posedge clk);
      #1;
      check("match", {31'd0, match}, {31'd0, e_match});
      check("cfg_err", {31'd0, cfg_err}, {31'd0, e_err});
      check("armed", {31'd0, armed}, {31'd0, m_armed});
      check("match_cnt", 32'(match_cnt), 32'(m_cnt));
   endtask

   task automatic load(input int len, input logic [MAX_LEN-1:0] pat, input logic ovl);
      cfg_len = LEN_W'(len);
      cfg_pattern = pat;
      cfg_overlap = ovl;
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic send(input logic b);
      tick(1'b0, 1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic send_bits(input logic [63:0] bits, input int n);
      logic [63:0] t;
      t = bits;
      for (int i = n - 1; i >= 0; i--) send(t[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_cnt();
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pi;
      int len;
      logic v, b, ld, clr, r;

      // Reset, including reset dominating every other control.
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cfg_len = LEN_W'(3); cfg_pattern = 16'b101; cfg_overlap = 1'b1;
      tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(1);
      send_bits(64'b101, 3);

      // Seven-bit pattern, overlap mode.
      load(7, 16'b1110110, 1'b1);
      send_bits(64'b1110110, 7);
      idle(2);
      check("s7_cnt", 32'(match_cnt), 32'd1);

      // 101 in overlap then non-overlap mode.
      clear_cnt();
      load(3, 16'b101, 1'b1);
      send_bits(64'b10101, 5);
      check("ovl_cnt", 32'(match_cnt), 32'd2);
      clear_cnt();
      load(3, 16'b101, 1'b0);
      send_bits(64'b10101, 5);
      check("novl_cnt", 32'(match_cnt), 32'd1);

      // Gaps in in_valid between bits 2 and 3.
      clear_cnt();
      load(3, 16'b101, 1'b1);
      send(1'b1); send(1'b0);
      idle(3);
      send(1'b1);
      check("gap_cnt", 32'(match_cnt), 32'd1);

      // Rejected loads: too short, too long.
      clear_cnt();
      load(1, 16'h0001, 1'b1);
      send_bits(64'b1111, 4);
      load(MAX_LEN + 1, 16'hFFFF, 1'b1);
      send_bits(64'hFFFF_FFFF, 20);
      check("bad_cnt", 32'(match_cnt), 32'd0);
      load(3, 16'b101, 1'b1);
      load(0, 16'b101, 1'b1);
      send_bits(64'b10101, 5);

      // Counter saturation and clear beating a detection.
      load(2, 16'b11, 1'b1);
      send(1'b1);
      for (int i = 0; i < 5; i++) send(1'b1);
      check("sat_cnt", 32'(match_cnt), 32'(CNT_MAX));
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      check("clr_win", 32'(match_cnt), 32'd0);

      // Reset mid-pattern, then load coinciding with the final bit.
      load(3, 16'b101, 1'b1);
      send(1'b1); send(1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send(1'b1);
      load(3, 16'b101, 1'b1);
      send(1'b1);
      send(1'b1); send(1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      send(1'b1);
      send(1'b0); send(1'b1);
      check("reload_cnt", 32'(match_cnt), 32'd1);

      // Pattern bits above the length are ignored.
      load(4, 16'hFFF9, 1'b0);
      send_bits(64'b1001, 4);
      check("upper_ign", 32'(match_cnt), 32'd2);

      // Random traffic; bits mostly follow the pattern so hits are frequent.
      pi = 0;
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 299) == 0);
         ld  = ($urandom_range(0, 39) == 0);
         clr = ($urandom_range(0, 49) == 0);
         v   = ($urandom_range(0, 9) < 8);
         if (ld) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 17)
                                              : $urandom_range(2, 6);
            cfg_len = LEN_W'(len);
            cfg_pattern = MAX_LEN'($urandom);
            cfg_overlap = $urandom_range(0, 1);
            pi = 0;
         end
         if (m_len >= 2 && $urandom_range(0, 9) < 7) begin
            b = m_pat[m_len - 1 - (pi % m_len)];
            if (v) pi++;
         end else begin
            b = $urandom_range(0, 1);
         end
         tick(r, v, b, ld, clr);
      end

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
